// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and fetch-state encoding for the fetch stage
//   NOP_INSTR        - addi x0,x0,0 placed on Instr when no valid word is held
//   RESET_PC_DEFAULT - default PC loaded by reset
//   fetch_state_e    - FETCH (request outstanding), HOLD (word held), FAULT (dead until reset)
package riscv_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory bus plus issue handshake toward decode
//   imem_req/imem_addr  - fetch request and address (fetch unit -> memory)
//   imem_ack/imem_rdata - read acknowledge and data (memory -> fetch unit)
//   Instr/instr_valid   - held instruction and its valid flag (fetch unit -> consumer)
//   instr_ready         - consumer accepts Instr (consumer -> fetch unit)
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        instr_ready;
    modport master (
        output imem_req, imem_addr, Instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, Instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_next_logic.sv
// pc_next_logic: combinational next-PC selection for the fetch stage
//   pc_i       - current PC
//   pc_src_i   - 1: branch taken (PC + imm), 0: sequential (PC + 4)
//   imm_ext_i  - sign-extended byte offset
//   next_o     - selected next PC (32-bit modulo)
//   pc_plus4_o - PC + 4
//   misalign_o - taken-branch target not word aligned
module pc_next_logic (
    input  logic [31:0] pc_i,
    input  logic        pc_src_i,
    input  logic [31:0] imm_ext_i,
    output logic [31:0] next_o,
    output logic [31:0] pc_plus4_o,
    output logic        misalign_o
);
    logic [31:0] target;
    always_comb begin
        pc_plus4_o = pc_i + 32'd4;
        target     = pc_i + imm_ext_i;
        next_o     = pc_src_i ? target : pc_plus4_o;
        misalign_o = pc_src_i && (target[1:0] != 2'b00);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, instruction-memory request, held Instr and memory watchdog
//   clk, areset        - clock and synchronous active-high reset
//   load               - PC advance enable from the control unit
//   PCSrc, ImmExt      - branch-taken select and byte offset for the next PC
//   bus (master)       - imem request/ack/data and Instr/instr_valid/instr_ready handshake
//   PC, PCPlus4        - current PC and PC + 4
//   fetch_fault        - sticky: memory never acknowledged or misaligned branch target
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 16,
    parameter int          TO_W     = 5
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      load,
    input  logic                      PCSrc,
    input  logic [31:0]               ImmExt,
    instr_fetch_unit_if.master        bus,
    output logic [31:0]               PC,
    output logic [31:0]               PCPlus4,
    output logic                      fetch_fault
);
    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            fault_q, fault_d;
    logic [31:0]     pc_next;
    logic            misalign;

    pc_next_logic u_pc_next (
        .pc_i      (pc_q),
        .pc_src_i  (PCSrc),
        .imm_ext_i (ImmExt),
        .next_o    (pc_next),
        .pc_plus4_o(PCPlus4),
        .misalign_o(misalign)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end

    // An ack on the watchdog's last cycle takes priority over expiry.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wd_d    = wd_q;
        fault_d = fault_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    wd_d    = '0;
                    state_d = HOLD;
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    instr_d = NOP_INSTR;
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            HOLD: begin
                if (bus.instr_ready && load) begin
                    if (misalign) begin
                        instr_d = NOP_INSTR;
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d    = pc_next;
                        wd_d    = '0;
                        state_d = FETCH;
                    end
                end
            end
            default: instr_d = NOP_INSTR;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == FETCH);
        bus.instr_valid = (state_q == HOLD);
        bus.imem_addr   = pc_q;
        bus.Instr       = instr_q;
        PC              = pc_q;
        fetch_fault     = fault_q;
    end
endmodule
